coder_tx: RTL

CODER_TX -- requirements
Module: coder_tx

---
 rtl/coder_pkg.sv | 27 ++
 rtl/coder_tx_if.sv | 35 +++
 rtl/coder_bit_timer.sv | 35 +++
 rtl/coder_tx.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/coder_pkg.sv
// -----------------------------------------------------------------------------
// coder_pkg -- shared types and constants for the coder_tx serial code sender.
//
//   CODE_W_DEF        default code-word width
//   coder_tx_state_t  FSM state encoding; the PARITY state only exists when
//                     CODER_TX_PARITY_EN is defined
//
// Config macro: CODER_TX_PARITY_EN (append one even-parity bit per word)
// -----------------------------------------------------------------------------
package coder_pkg;

    localparam int CODE_W_DEF = 4;

`ifdef CODER_TX_PARITY_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } coder_tx_state_t;
`else
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } coder_tx_state_t;
`endif

endpackage

// File: rtl/coder_tx_if.sv
// -----------------------------------------------------------------------------
// coder_tx_if -- request/status bundle of the coder_tx serial code sender.
//
//   start, abort     request / terminate a transmission
//   code [CODE_W]    code word, latched on accepted start
//   reps [4]         repeat count, words sent = reps+1
//   out              serial bit, MSB first
//   bit_valid        out carries a code or parity bit
//   busy             transmission in progress
//   done             one-cycle pulse after the final bit
//
// master: the requester; slave: coder_tx.
// -----------------------------------------------------------------------------
interface coder_tx_if #(
    parameter int CODE_W = 4
);
    logic              start;
    logic              abort;
    logic [CODE_W-1:0] code;
    logic [3:0]        reps;
    logic              out;
    logic              bit_valid;
    logic              busy;
    logic              done;

    modport master (
        output start, abort, code, reps,
        input  out, bit_valid, busy, done
    );

    modport slave (
        input  start, abort, code, reps,
        output out, bit_valid, busy, done
    );
endinterface

// File: rtl/coder_bit_timer.sv
// -----------------------------------------------------------------------------
// coder_bit_timer -- bit-period counter.
//
//   clk, rst   clock, synchronous active-high reset
//   load       restart the period (counter held at zero while asserted)
//   tick       one-cycle pulse in the last cycle of every BIT_CYCLES period
//
// BIT_CYCLES legal range 1..255.
// -----------------------------------------------------------------------------
module coder_bit_timer #(
    parameter int BIT_CYCLES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic tick
);
    localparam logic [7:0] LAST = 8'(BIT_CYCLES - 1);

    logic [7:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || load)
            cnt <= 8'd0;
        else if (cnt == LAST)
            cnt <= 8'd0;
        else
            cnt <= cnt + 8'd1;
    end

    // Suppressed during load so the cycle that restarts the period never
    // advances the shifter.
    assign tick = !load && (cnt == LAST);

endmodule

// File: rtl/coder_tx.sv
// -----------------------------------------------------------------------------
// coder_tx -- serial code-word transmitter.
//
// Sends a latched code word MSB first, reps+1 times back to back, each bit
// held BIT_CYCLES clocks. done pulses for one cycle after the final bit.
//
//   clk, rst   clock, synchronous active-high reset
//   bus        coder_tx_if.slave (start/abort/code/reps in,
//              out/bit_valid/busy/done out)
//
// Config macro: CODER_TX_PARITY_EN -- each word is followed by one bit period
// carrying the even parity (XOR) of the word.
// -----------------------------------------------------------------------------
module coder_tx
    import coder_pkg::*;
#(
    parameter int CODE_W     = CODE_W_DEF,
    parameter int BIT_CYCLES = 1
) (
    input  logic         clk,
    input  logic         rst,
    coder_tx_if.slave    bus
);
    localparam int IDX_W = (CODE_W > 1) ? $clog2(CODE_W) : 1;
    localparam logic [IDX_W-1:0] MSB_IDX = IDX_W'(CODE_W - 1);

    coder_tx_state_t   state, state_nxt;
    logic [CODE_W-1:0] shreg, shreg_nxt;
    logic [CODE_W-1:0] code_q, code_nxt;
    logic [IDX_W-1:0]  idx, idx_nxt;
    logic [3:0]        word_cnt, word_nxt;
    logic              done_q, done_nxt;
    logic              word_end;
    logic              tick;
    logic              timer_load;

    // Timer is held in restart whenever idle, so the first bit period of a
    // transmission always starts from zero.
    assign timer_load = (state == IDLE);

    coder_bit_timer #(
        .BIT_CYCLES (BIT_CYCLES)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .load (timer_load),
        .tick (tick)
    );

    always_comb begin
        state_nxt = state;
        shreg_nxt = shreg;
        code_nxt  = code_q;
        idx_nxt   = idx;
        word_nxt  = word_cnt;
        done_nxt  = 1'b0;
        word_end  = 1'b0;

        case (state)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    state_nxt = SHIFT;
                    shreg_nxt = bus.code;
                    code_nxt  = bus.code;
                    idx_nxt   = MSB_IDX;
                    word_nxt  = bus.reps;
                end
            end
            SHIFT: begin
                if (bus.abort) begin
                    state_nxt = IDLE;
                end else if (tick) begin
                    if (idx == '0) begin
`ifdef CODER_TX_PARITY_EN
                        state_nxt = PARITY;
`else
                        word_end  = 1'b1;
`endif
                    end else begin
                        shreg_nxt = shreg << 1;
                        idx_nxt   = idx - IDX_W'(1);
                    end
                end
            end
`ifdef CODER_TX_PARITY_EN
            PARITY: begin
                if (bus.abort)
                    state_nxt = IDLE;
                else if (tick)
                    word_end = 1'b1;
            end
`endif
            default: state_nxt = IDLE;
        endcase

        // Last bit period of a word: reload the next copy with no gap, or
        // finish and raise done for the following cycle.
        if (word_end) begin
            if (word_cnt == 4'd0) begin
                state_nxt = IDLE;
                done_nxt  = 1'b1;
            end else begin
                state_nxt = SHIFT;
                word_nxt  = word_cnt - 4'd1;
                shreg_nxt = code_q;
                idx_nxt   = MSB_IDX;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            shreg    <= '0;
            code_q   <= '0;
            idx      <= '0;
            word_cnt <= 4'd0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            shreg    <= shreg_nxt;
            code_q   <= code_nxt;
            idx      <= idx_nxt;
            word_cnt <= word_nxt;
            done_q   <= done_nxt;
        end
    end

    always_comb begin
        bus.out = 1'b0;
        if (state == SHIFT)
            bus.out = shreg[CODE_W-1];
`ifdef CODER_TX_PARITY_EN
        else if (state == PARITY)
            bus.out = ^code_q;
`endif
    end

    assign bus.busy      = (state != IDLE);
    assign bus.bit_valid = (state != IDLE);
    assign bus.done      = done_q;

endmodule
